wav_playback_stage: RTL and testbench

Downstream consumer of the HPS WAV output FIFO stream (32-bit valid/ready). It buffers stereo PCM words and releases one word per codec sample tick, gated by the play control. It applies a ramped 7-bit volume gain and presents left/right samples to the DAC serializer. It also reports underruns and volume-ramp status back to the HPS PIOs.

---
 rtl/audio_pkg.sv | 9 +
 rtl/wav_playback_stage_if.sv | 8 +
 rtl/stream_fifo.sv | 46 ++++
 rtl/wav_playback_stage.sv | 112 +++++++++++
 tb/tb_wav_playback_stage.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, volume constants, stereo slicing and playback states
package audio_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int VOL_W = 7;
    localparam logic [VOL_W-1:0] VOL_UNITY = 7'd127;
    localparam int L_MSB = 31;
    localparam int R_MSB = 15;
    typedef enum logic [1:0] {STOP, FILL, RUN} state_t;
endpackage

// File: rtl/wav_playback_stage_if.sv
// wav_stream_if: 32-bit valid/ready stream carrying packed stereo PCM words
interface wav_stream_if;
    logic        valid;
    logic [31:0] data;
    logic        ready;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: DEPTH x W first-word-fallthrough FIFO with full/empty/count
module stream_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    always_comb begin
        full = count_q == (AW+1)'(DEPTH);
        empty = count_q == '0;
        do_push = push && !full;
        do_pop = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        rdata = mem[rd_ptr_q];
        count = count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/wav_playback_stage.sv
// wav_playback_stage: buffers WAV stream words, releases one per sample tick through
// a two-stage ramped-gain pipeline, and reports underruns and volume-ramp status.
module wav_playback_stage
    import audio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int FILL_LEVEL = 2,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    wav_stream_if.slave         in_if,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                vol_set,
    input  logic [VOL_W-1:0]    vol,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_left,
    output logic [DATA_W-1:0]   out_right,
    output logic                vol_busy,
    output logic [15:0]         underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]              fifo_rdata;
    logic                     full, empty, pop, underrun;
    logic [AW:0]              count;
    logic signed [DATA_W-1:0] s_l, s_r;
    state_t                   state_q, state_d;
    logic [VOL_W-1:0]         cur_vol_q, cur_vol_d, target_q, target_d;
    logic                     s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, vol_busy_q, vol_busy_d;
    logic signed [DATA_W-1:0] s1_l_q, s1_l_d, s1_r_q, s1_r_d;
    logic [DATA_W-1:0]        out_left_q, out_left_d, out_right_q, out_right_d;
    logic [15:0]              underrun_cnt_q, underrun_cnt_d;

    // Arithmetic shift of the widened product rounds toward -inf; 127 is exact unity.
    function automatic logic signed [DATA_W-1:0] gain(input logic signed [DATA_W-1:0] s,
                                                      input logic [VOL_W-1:0] v);
        logic signed [DATA_W+VOL_W:0] p;
        p = (DATA_W+VOL_W+1)'(s) * (DATA_W+VOL_W+1)'(signed'({1'b0, v}));
        return v == VOL_UNITY ? s : DATA_W'(p >>> VOL_W);
    endfunction

    assign in_if.ready = !full;

    stream_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (in_if.valid && !full),
        .pop   (pop),
        .wdata (in_if.data),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        pop = sample_tick && state_q == RUN && !empty;
        underrun = sample_tick && state_q == RUN && empty;
        s_l = pop ? signed'(fifo_rdata[L_MSB -: DATA_W]) : '0;
        s_r = pop ? signed'(fifo_rdata[R_MSB -: DATA_W]) : '0;
        state_d = !play ? STOP
                : state_q == STOP ? FILL
                : state_q == FILL && count >= (AW+1)'(FILL_LEVEL) ? RUN
                : underrun ? FILL : state_q;
        target_d = vol_set ? vol : target_q;
        cur_vol_d = !sample_tick || cur_vol_q == target_q ? cur_vol_q
                  : cur_vol_q < target_q ? cur_vol_q + VOL_W'(1) : cur_vol_q - VOL_W'(1);
        vol_busy_d = cur_vol_d != target_d;
        s1_valid_d = sample_tick;
        s1_l_d = sample_tick ? gain(s_l, cur_vol_q) : s1_l_q;
        s1_r_d = sample_tick ? gain(s_r, cur_vol_q) : s1_r_q;
        out_valid_d = s1_valid_q;
        out_left_d = s1_valid_q ? s1_l_q : out_left_q;
        out_right_d = s1_valid_q ? s1_r_q : out_right_q;
        underrun_cnt_d = underrun && underrun_cnt_q != '1 ? underrun_cnt_q + 16'd1 : underrun_cnt_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= STOP;
            cur_vol_q <= '0;
            target_q <= '0;
            vol_busy_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_l_q <= '0;
            s1_r_q <= '0;
            out_valid_q <= 1'b0;
            out_left_q <= '0;
            out_right_q <= '0;
            underrun_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cur_vol_q <= cur_vol_d;
            target_q <= target_d;
            vol_busy_q <= vol_busy_d;
            s1_valid_q <= s1_valid_d;
            s1_l_q <= s1_l_d;
            s1_r_q <= s1_r_d;
            out_valid_q <= out_valid_d;
            out_left_q <= out_left_d;
            out_right_q <= out_right_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_left = out_left_q;
    assign out_right = out_right_q;
    assign vol_busy = vol_busy_q;
    assign underrun_cnt = underrun_cnt_q;
endmodule

// File: tb/tb_wav_playback_stage.sv
// tb_wav_playback_stage: directed scenario tasks with hand-computed expectations
module tb_wav_playback_stage;
    import audio_pkg::*;
    logic        clk_clk = 0, reset_reset_n = 0;
    logic        sample_tick = 0, play = 0, vol_set = 0;
    logic [6:0]  vol = 0;
    logic        out_valid, vol_busy;
    logic [15:0] out_left, out_right, underrun_cnt;
    int          errors = 0, checks = 0;
    logic        v0, v1, v2;
    logic [15:0] cl, cr;

    wav_stream_if s_if();

    wav_playback_stage dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .in_if(s_if),
        .sample_tick(sample_tick), .play(play), .vol_set(vol_set), .vol(vol),
        .out_valid(out_valid), .out_left(out_left), .out_right(out_right),
        .vol_busy(vol_busy), .underrun_cnt(underrun_cnt)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic tick_capture();
        sample_tick = 1; step(); v0 = out_valid;
        sample_tick = 0; step(); v1 = out_valid; cl = out_left; cr = out_right;
        step(); v2 = out_valid;
    endtask

    task automatic set_vol(input logic [6:0] v);
        vol = v; vol_set = 1; step(); vol_set = 0;
    endtask

    task automatic ticks(input int n, output int pulses);
        pulses = 0;
        sample_tick = 1;
        for (int i = 0; i < n + 2; i++) begin
            if (i == n) sample_tick = 0;
            step();
            if (out_valid) pulses++;
        end
    endtask

    task automatic push2(input logic [31:0] a, input logic [31:0] b);
        s_if.valid = 1; s_if.data = a; step();
        s_if.data = b; step();
        s_if.valid = 0;
    endtask

    task automatic test_reset();
        s_if.valid = 0; s_if.data = 0;
        repeat (2) @(posedge clk_clk);
        #1;
        checks++; if (s_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", s_if.ready); end
        checks++; if ({out_valid, vol_busy, out_left, out_right, underrun_cnt} !== 50'd0) begin errors++; $display("FAIL reset_outputs got %b %b %h %h %h exp zeros", out_valid, vol_busy, out_left, out_right, underrun_cnt); end
        checks++; if (dut.state_q !== STOP || dut.cur_vol_q !== 7'd0) begin errors++; $display("FAIL reset_state got %0d vol %0d exp STOP 0", dut.state_q, dut.cur_vol_q); end
        reset_reset_n = 1; step();
    endtask

    task automatic test_ramp();
        logic [6:0] ev [4] = '{7'd1, 7'd2, 7'd3, 7'd3};
        logic       eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        set_vol(7'd3);
        checks++; if (vol_busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_set got %b exp 1", vol_busy); end
        for (int i = 0; i < 4; i++) begin
            tick_capture();
            checks++; if (dut.cur_vol_q !== ev[i] || vol_busy !== eb[i]) begin errors++; $display("FAIL ramp_step%0d got vol %0d busy %b exp %0d %b", i, dut.cur_vol_q, vol_busy, ev[i], eb[i]); end
        end
        vol = 7'd5; vol_set = 1; sample_tick = 1; step(); vol_set = 0; sample_tick = 0;
        checks++; if (dut.cur_vol_q !== 7'd3 || vol_busy !== 1'b1) begin errors++; $display("FAIL ramp_coincident got vol %0d busy %b exp 3 1", dut.cur_vol_q, vol_busy); end
        tick_capture();
        checks++; if (dut.cur_vol_q !== 7'd4) begin errors++; $display("FAIL ramp_after_coincident got %0d exp 4", dut.cur_vol_q); end
    endtask

    task automatic test_back_to_back();
        int p;
        set_vol(7'd127);
        ticks(130, p);
        checks++; if (p !== 130) begin errors++; $display("FAIL b2b_pulses got %0d exp 130", p); end
        checks++; if (dut.cur_vol_q !== 7'd127 || vol_busy !== 1'b0 || out_left !== 16'd0) begin errors++; $display("FAIL b2b_vol got %0d busy %b left %h exp 127 0 0000", dut.cur_vol_q, vol_busy, out_left); end
    endtask

    task automatic test_play();
        play = 1; step();
        push2(32'h1000_F000, 32'h2000_E000);
        step();
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL play_run got %0d exp RUN", dut.state_q); end
        tick_capture();
        checks++; if ({v0, v1, v2} !== 3'b010 || cl !== 16'h1000 || cr !== 16'hF000) begin errors++; $display("FAIL play_word0 got %b%b%b %h/%h exp 010 1000/f000", v0, v1, v2, cl, cr); end
        tick_capture();
        checks++; if ({v0, v1, v2} !== 3'b010 || cl !== 16'h2000 || cr !== 16'hE000) begin errors++; $display("FAIL play_word1 got %b%b%b %h/%h exp 010 2000/e000", v0, v1, v2, cl, cr); end
        checks++; if (out_left !== 16'h2000) begin errors++; $display("FAIL play_hold got %h exp 2000", out_left); end
    endtask

    task automatic test_underrun();
        push2(32'h1234_8765, 32'h7FFF_8000);
        tick_capture();
        checks++; if (v1 !== 1'b1 || cl !== 16'h1234 || cr !== 16'h8765) begin errors++; $display("FAIL und_word0 got %b %h/%h exp 1 1234/8765", v1, cl, cr); end
        tick_capture();
        checks++; if (v1 !== 1'b1 || cl !== 16'h7FFF || cr !== 16'h8000) begin errors++; $display("FAIL und_word1 got %b %h/%h exp 1 7fff/8000", v1, cl, cr); end
        tick_capture();
        checks++; if (v1 !== 1'b1 || cl !== 16'h0 || cr !== 16'h0 || underrun_cnt !== 16'd1 || dut.state_q !== FILL) begin errors++; $display("FAIL und_zero got %b %h/%h cnt %0d st %0d exp 1 0/0 1 FILL", v1, cl, cr, underrun_cnt, dut.state_q); end
        tick_capture();
        checks++; if (v1 !== 1'b1 || underrun_cnt !== 16'd1) begin errors++; $display("FAIL und_fill_tick got %b cnt %0d exp 1 1", v1, underrun_cnt); end
    endtask

    task automatic test_gain();
        int p;
        set_vol(7'd64); ticks(63, p);
        checks++; if (dut.cur_vol_q !== 7'd64) begin errors++; $display("FAIL gain_vol64 got %0d exp 64", dut.cur_vol_q); end
        push2(32'h7FFF_8000, 32'hFFFF_FFFF);
        step();
        tick_capture();
        checks++; if (cl !== 16'h3FFF || cr !== 16'hC000) begin errors++; $display("FAIL gain_half got %h/%h exp 3fff/c000", cl, cr); end
        play = 0; step();
        set_vol(7'd1); ticks(63, p);
        play = 1; s_if.valid = 1; s_if.data = 32'h0080_FF80; step();
        s_if.valid = 0; step();
        checks++; if (dut.state_q !== RUN || dut.cur_vol_q !== 7'd1) begin errors++; $display("FAIL gain_rerun got st %0d vol %0d exp RUN 1", dut.state_q, dut.cur_vol_q); end
        tick_capture();
        checks++; if (cl !== 16'hFFFF || cr !== 16'hFFFF) begin errors++; $display("FAIL gain_trunc got %h/%h exp ffff/ffff", cl, cr); end
        tick_capture();
        checks++; if (cl !== 16'h0001 || cr !== 16'hFFFF) begin errors++; $display("FAIL gain_vol1 got %h/%h exp 0001/ffff", cl, cr); end
    endtask

    task automatic test_full_stop();
        logic [31:0] w [6] = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008, 32'h0009_000A, 32'h000B_000C};
        int acc = 0, p;
        play = 0; step();
        set_vol(7'd127); ticks(126, p);
        s_if.valid = 1;
        for (int i = 0; i < 6; i++) begin
            s_if.data = w[i];
            if (s_if.ready) acc++;
            step();
        end
        s_if.valid = 0;
        checks++; if (acc !== 4 || s_if.ready !== 1'b0) begin errors++; $display("FAIL full_accept got %0d ready %b exp 4 0", acc, s_if.ready); end
        tick_capture();
        checks++; if (v1 !== 1'b1 || cl !== 16'h0 || cr !== 16'h0 || s_if.ready !== 1'b0) begin errors++; $display("FAIL full_stop_tick got %b %h/%h ready %b exp 1 0/0 0", v1, cl, cr, s_if.ready); end
        play = 1; step(); step();
        for (int i = 0; i < 4; i++) begin
            tick_capture();
            checks++; if ({cl, cr} !== w[i] || s_if.ready !== 1'b1) begin errors++; $display("FAIL full_order%0d got %h%h ready %b exp %h 1", i, cl, cr, s_if.ready, w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int p = 0;
        push2(32'h5555_AAAA, 32'h6666_9999);
        sample_tick = 1; step(); sample_tick = 0;
        #2 reset_reset_n = 0;
        #1;
        checks++; if ({out_valid, out_left, out_right, underrun_cnt} !== 49'd0 || s_if.ready !== 1'b1) begin errors++; $display("FAIL rst_mid_out got %b %h %h %h ready %b exp zeros 1", out_valid, out_left, out_right, underrun_cnt, s_if.ready); end
        checks++; if (dut.state_q !== STOP || dut.cur_vol_q !== 7'd0) begin errors++; $display("FAIL rst_mid_state got %0d vol %0d exp STOP 0", dut.state_q, dut.cur_vol_q); end
        step(); reset_reset_n = 1;
        for (int i = 0; i < 4; i++) begin step(); if (out_valid) p++; end
        checks++; if (p !== 0) begin errors++; $display("FAIL rst_mid_nopulse got %0d exp 0", p); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_play();
        test_underrun();
        test_gain();
        test_full_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
